// File: rtl/pe_sequencer_if.sv
// Bundle between the PE sequencer and its environment: job control, global-buffer
// streams and the PE scratchpad load/compute port.
interface pe_sequencer_if #(
    parameter int DW       = 8,
    parameter int FILT_AW  = 6,
    parameter int IFMAP_AW = 4,
    parameter int PSUM_AW  = 4
);
    logic                start;
    logic [FILT_AW-1:0]  cfg_filt_base;
    logic [4:0]          cfg_filt_len;
    logic [4:0]          cfg_ifmap_len;

    logic [DW-1:0]       gb_filt_data;
    logic                gb_filt_valid;
    logic                gb_filt_ready;
    logic [DW-1:0]       gb_ifmap_data;
    logic                gb_ifmap_valid;
    logic                gb_ifmap_ready;

    logic                load_filter;
    logic [FILT_AW-1:0]  ld_addr_filter;
    logic [DW-1:0]       filter;
    logic                load_ifmap;
    logic [IFMAP_AW-1:0] ld_addr_ifmap;
    logic [DW-1:0]       ifmap;
    logic                en;
    logic [FILT_AW-1:0]  sel_filter_addr;
    logic [IFMAP_AW-1:0] sel_ifmap_addr;
    logic [PSUM_AW-1:0]  psum_sel;

    logic                busy;
    logic                done;
    logic                err;

    modport master (
        input  start, cfg_filt_base, cfg_filt_len, cfg_ifmap_len,
        input  gb_filt_data, gb_filt_valid, gb_ifmap_data, gb_ifmap_valid,
        output gb_filt_ready, gb_ifmap_ready,
        output load_filter, ld_addr_filter, filter,
        output load_ifmap, ld_addr_ifmap, ifmap,
        output en, sel_filter_addr, sel_ifmap_addr, psum_sel,
        output busy, done, err
    );

    modport slave (
        output start, cfg_filt_base, cfg_filt_len, cfg_ifmap_len,
        output gb_filt_data, gb_filt_valid, gb_ifmap_data, gb_ifmap_valid,
        input  gb_filt_ready, gb_ifmap_ready,
        input  load_filter, ld_addr_filter, filter,
        input  load_ifmap, ld_addr_ifmap, ifmap,
        input  en, sel_filter_addr, sel_ifmap_addr, psum_sel,
        input  busy, done, err
    );
endinterface

// File: rtl/pe_sequencer.sv
// Loads one PE's filter/ifmap scratchpads from global-buffer streams, then issues the
// 1-D convolution address sequence, drains the PE pipeline and pulses done.
module pe_sequencer #(
    parameter int DW       = 8,
    parameter int FILT_AW  = 6,
    parameter int IFMAP_AW = 4,
    parameter int PSUM_AW  = 4,
    parameter int PE_LAT   = 3
) (
    input  logic              clk,
    input  logic              rst,
    pe_sequencer_if.master    bus
);
    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_LOAD_FILT  = 3'd1;
    localparam logic [2:0] S_LOAD_IFMAP = 3'd2;
    localparam logic [2:0] S_COMPUTE    = 3'd3;
    localparam logic [2:0] S_DRAIN      = 3'd4;
    localparam logic [2:0] S_DONE       = 3'd5;

    logic [2:0]         r_state;
    logic [FILT_AW-1:0] r_base;
    logic [4:0]         r_len_s;
    logic [4:0]         r_len_w;
    logic [4:0]         r_cnt;
    logic [4:0]         r_s;
    logic [4:0]         r_e;

    logic w_filt_xfer;
    logic w_ifmap_xfer;
    logic w_cfg_bad;
    logic w_last_tap;
    logic w_last_out;

    assign bus.gb_filt_ready  = (r_state == S_LOAD_FILT)  && (r_cnt < r_len_s);
    assign bus.gb_ifmap_ready = (r_state == S_LOAD_IFMAP) && (r_cnt < r_len_w);
    assign bus.busy           = (r_state != S_IDLE);

    assign w_filt_xfer  = bus.gb_filt_valid  && bus.gb_filt_ready;
    assign w_ifmap_xfer = bus.gb_ifmap_valid && bus.gb_ifmap_ready;
    assign w_cfg_bad    = (bus.cfg_filt_len == 5'd0) ||
                          (bus.cfg_filt_len > bus.cfg_ifmap_len) ||
                          (bus.cfg_ifmap_len > 5'd16);
    assign w_last_tap   = (r_s == r_len_s - 5'd1);
    // Last output index is E-1 = W-S.
    assign w_last_out   = (r_e == r_len_w - r_len_s);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state             <= S_IDLE;
            r_base              <= '0;
            r_len_s             <= '0;
            r_len_w             <= '0;
            r_cnt               <= '0;
            r_s                 <= '0;
            r_e                 <= '0;
            bus.load_filter     <= 1'b0;
            bus.ld_addr_filter  <= '0;
            bus.filter          <= '0;
            bus.load_ifmap      <= 1'b0;
            bus.ld_addr_ifmap   <= '0;
            bus.ifmap           <= '0;
            bus.en              <= 1'b0;
            bus.sel_filter_addr <= '0;
            bus.sel_ifmap_addr  <= '0;
            bus.psum_sel        <= '0;
            bus.done            <= 1'b0;
            bus.err             <= 1'b0;
        end else begin
            bus.load_filter <= 1'b0;
            bus.load_ifmap  <= 1'b0;
            bus.en          <= 1'b0;
            bus.done        <= 1'b0;
            bus.err         <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_base  <= bus.cfg_filt_base;
                        r_len_s <= bus.cfg_filt_len;
                        r_len_w <= bus.cfg_ifmap_len;
                        r_cnt   <= '0;
                        if (w_cfg_bad) bus.err <= 1'b1;
                        else           r_state <= S_LOAD_FILT;
                    end
                end
                S_LOAD_FILT: begin
                    if (w_filt_xfer) begin
                        bus.load_filter    <= 1'b1;
                        bus.ld_addr_filter <= r_base + FILT_AW'(r_cnt);
                        bus.filter         <= bus.gb_filt_data;
                        if (r_cnt == r_len_s - 5'd1) begin
                            r_cnt   <= '0;
                            r_state <= S_LOAD_IFMAP;
                        end else begin
                            r_cnt <= r_cnt + 5'd1;
                        end
                    end
                end
                S_LOAD_IFMAP: begin
                    if (w_ifmap_xfer) begin
                        bus.load_ifmap    <= 1'b1;
                        bus.ld_addr_ifmap <= IFMAP_AW'(r_cnt);
                        bus.ifmap         <= bus.gb_ifmap_data;
                        if (r_cnt == r_len_w - 5'd1) begin
                            r_cnt   <= '0;
                            r_s     <= '0;
                            r_e     <= '0;
                            r_state <= S_COMPUTE;
                        end else begin
                            r_cnt <= r_cnt + 5'd1;
                        end
                    end
                end
                S_COMPUTE: begin
                    bus.en              <= 1'b1;
                    bus.sel_filter_addr <= r_base + FILT_AW'(r_s);
                    bus.sel_ifmap_addr  <= IFMAP_AW'(r_e + r_s);
                    bus.psum_sel        <= PSUM_AW'(r_e);
                    if (w_last_tap) begin
                        r_s <= '0;
                        r_e <= r_e + 5'd1;
                        if (w_last_out) begin
                            r_cnt   <= '0;
                            r_state <= S_DRAIN;
                        end
                    end else begin
                        r_s <= r_s + 5'd1;
                    end
                end
                S_DRAIN: begin
                    // First DRAIN cycle still shows the final registered en, so
                    // PE_LAT idle cycles follow before done.
                    if (r_cnt == 5'(PE_LAT)) begin
                        bus.done <= 1'b1;
                        r_state  <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 5'd1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pe_sequencer.sv
// Scoreboard bench for pe_sequencer: expected PE-port writes and MAC addresses are
// queued when a job is started and popped as the DUT emits them.
module tb_pe_sequencer;
    localparam int DW       = 8;
    localparam int FILT_AW  = 6;
    localparam int IFMAP_AW = 4;
    localparam int PSUM_AW  = 4;
    localparam int PE_LAT   = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pe_sequencer_if #(.DW(DW), .FILT_AW(FILT_AW), .IFMAP_AW(IFMAP_AW), .PSUM_AW(PSUM_AW)) bus();

    pe_sequencer #(
        .DW(DW), .FILT_AW(FILT_AW), .IFMAP_AW(IFMAP_AW), .PSUM_AW(PSUM_AW), .PE_LAT(PE_LAT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_vec = 0;
    int n_bad = 0;

    logic [31:0] q_filt[$];
    logic [31:0] q_ifmap[$];
    logic [31:0] q_en[$];

    int en_cnt, en_runs, gap, gap_at_done, done_cnt, err_cnt;
    bit overlap, prev_en;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        en_cnt = 0; en_runs = 0; gap = 0; gap_at_done = -1;
        done_cnt = 0; err_cnt = 0; overlap = 0; prev_en = 0;
    endtask

    // Monitor: pops the scoreboard on every PE-side strobe.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                if (bus.done) begin
                    done_cnt++;
                    gap_at_done = gap;
                end
                if (bus.err) err_cnt++;
                if (bus.load_filter && bus.load_ifmap) overlap = 1;
                if (bus.load_filter) begin
                    if (q_filt.size() == 0)
                        check("ld_filt_unexp", {1'b1, bus.ld_addr_filter, bus.filter}, 0);
                    else
                        check("ld_filt", 32'({bus.ld_addr_filter, bus.filter}), q_filt.pop_front());
                end
                if (bus.load_ifmap) begin
                    if (q_ifmap.size() == 0)
                        check("ld_ifmap_unexp", {1'b1, bus.ld_addr_ifmap, bus.ifmap}, 0);
                    else
                        check("ld_ifmap", 32'({bus.ld_addr_ifmap, bus.ifmap}), q_ifmap.pop_front());
                end
                if (bus.en) begin
                    en_cnt++;
                    if (!prev_en) en_runs++;
                    gap = 0;
                    if (q_en.size() == 0)
                        check("en_unexp", {1'b1, bus.sel_filter_addr, bus.sel_ifmap_addr, bus.psum_sel}, 0);
                    else
                        check("mac_addr", 32'({bus.sel_filter_addr, bus.sel_ifmap_addr, bus.psum_sel}),
                              q_en.pop_front());
                end else begin
                    gap++;
                end
                prev_en = bus.en;
            end
        end
    end

    task automatic push_expect(input int base, input int s_len, input int w_len,
                               input int ff, input int fi);
        for (int k = 0; k < s_len; k++)
            q_filt.push_back(32'((((base + k) & 63) << 8) | ((ff + k) & 255)));
        for (int k = 0; k < w_len; k++)
            q_ifmap.push_back(32'((k << 8) | ((fi + k) & 255)));
        for (int e = 0; e < w_len - s_len + 1; e++)
            for (int s = 0; s < s_len; s++)
                q_en.push_back(32'((((base + s) & 63) << 8) | (((e + s) & 15) << 4) | (e & 15)));
    endtask

    // Entered and left at posedge+1.
    task automatic start_job(input int base, input int s_len, input int w_len,
                             input int ff, input int fi, input bit hold);
        bit legal;
        legal = (s_len >= 1) && (s_len <= w_len) && (w_len <= 16);
        if (legal) push_expect(base, s_len, w_len, ff, fi);
        bus.cfg_filt_base = FILT_AW'(base);
        bus.cfg_filt_len  = 5'(s_len);
        bus.cfg_ifmap_len = 5'(w_len);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) bus.start = 1'b0;
        check("busy_after_start", bus.busy, legal);
        check("err_after_start", bus.err, !legal);
    endtask

    task automatic feed(input bit sel, input int n, input int first, input logic [31:0] mask);
        int k, cyc;
        logic rdy, v;
        k = 0;
        cyc = 0;
        while (k < n && cyc < 200) begin
            v = (cyc < 32) ? mask[cyc] : 1'b1;
            if (sel) begin
                bus.gb_ifmap_valid = v; bus.gb_ifmap_data = DW'(first + k);
            end else begin
                bus.gb_filt_valid = v;  bus.gb_filt_data  = DW'(first + k);
            end
            @(negedge clk);
            rdy = sel ? bus.gb_ifmap_ready : bus.gb_filt_ready;
            @(posedge clk);
            #1;
            if (v && rdy) k++;
            cyc++;
        end
        if (sel) bus.gb_ifmap_valid = 1'b0;
        else     bus.gb_filt_valid  = 1'b0;
        check(sel ? "ifmap_words" : "filt_words", k, n);
    endtask

    // Waits for done, then checks completion bookkeeping in the following IDLE cycle.
    task automatic wait_done();
        int i;
        for (i = 0; i < 400; i++) begin
            if (bus.done) break;
            @(posedge clk);
            #1;
        end
        check("done_seen", bus.done, 1);
        check("busy_at_done", bus.busy, 1);
        @(posedge clk);
        #1;
        check("busy_after_done", bus.busy, 0);
        check("done_width", {bus.done, 32'(done_cnt)}, {1'b0, 32'd1});
        check("drain_gap", gap_at_done, PE_LAT);
        check("en_contiguous", en_runs, 1);
        check("queues_empty", q_filt.size() + q_ifmap.size() + q_en.size(), 0);
        check("ld_overlap", overlap, 0);
    endtask

    task automatic run_job(input int base, input int s_len, input int w_len,
                           input int ff, input int fi, input logic [31:0] fmask);
        clear_stats();
        start_job(base, s_len, w_len, ff, fi, 1'b0);
        feed(1'b0, s_len, ff, fmask);
        feed(1'b1, w_len, fi, '1);
        wait_done();
    endtask

    initial begin
        #300_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad_s[3];
        int bad_w[3];
        bus.start = 0; bus.cfg_filt_base = '0; bus.cfg_filt_len = '0; bus.cfg_ifmap_len = '0;
        bus.gb_filt_data = '0; bus.gb_filt_valid = 0; bus.gb_ifmap_data = '0; bus.gb_ifmap_valid = 0;
        clear_stats();

        #2;
        check("reset_outputs",
              {bus.load_filter, bus.ld_addr_filter, bus.filter, bus.load_ifmap, bus.ld_addr_ifmap,
               bus.ifmap, bus.en, bus.sel_filter_addr, bus.sel_ifmap_addr, bus.psum_sel,
               bus.busy, bus.done, bus.err, bus.gb_filt_ready, bus.gb_ifmap_ready}, 0);
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk);
        #1;

        // Basic run; stray ifmap data offered during filter load must not be consumed.
        bus.gb_ifmap_valid = 1'b1; bus.gb_ifmap_data = 8'hEE;
        run_job(10, 3, 5, 1, 4, '1);

        // Filter valid stalls 1,0,0,1,1.
        run_job(20, 3, 4, 8'h30, 8'h40, 32'b11001);

        // Rejected configurations, then a legal one.
        bad_s = '{6, 0, 2};
        bad_w = '{4, 4, 17};
        for (int i = 0; i < 3; i++) begin
            clear_stats();
            start_job(0, bad_s[i], bad_w[i], 0, 0, 1'b0);
            repeat (8) @(posedge clk);
            #1;
            check("bad_cfg_err_count", err_cnt, 1);
            check("bad_cfg_idle", {bus.busy, 32'(en_cnt)}, 0);
        end
        run_job(5, 2, 6, 8'h11, 8'h21, '1);

        // Edge configurations.
        run_job(63, 1, 16, 8'h50, 8'h60, '1);
        run_job(50, 16, 16, 8'h70, 8'h80, '1);

        // Reset in the middle of COMPUTE.
        clear_stats();
        start_job(7, 4, 8, 8'h90, 8'hA0, 1'b0);
        feed(1'b0, 4, 8'h90, '1);
        feed(1'b1, 8, 8'hA0, '1);
        for (int i = 0; i < 100 && en_cnt < 4; i++) begin
            @(posedge clk);
            #2;
        end
        check("en_before_reset", en_cnt, 4);
        #1 rst = 1'b0;
        #1;
        check("reset_mid_compute",
              {bus.load_filter, bus.ld_addr_filter, bus.filter, bus.load_ifmap, bus.ld_addr_ifmap,
               bus.ifmap, bus.en, bus.sel_filter_addr, bus.sel_ifmap_addr, bus.psum_sel,
               bus.busy, bus.done, bus.err, bus.gb_filt_ready, bus.gb_ifmap_ready}, 0);
        q_filt.delete(); q_ifmap.delete(); q_en.delete();
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        bus.gb_filt_valid = 1'b1; bus.gb_ifmap_valid = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        bus.gb_filt_valid = 1'b0; bus.gb_ifmap_valid = 1'b0;
        check("idle_after_reset", {bus.busy, 32'(en_cnt), 32'(done_cnt)}, {1'b0, 32'd4, 32'd0});

        // start held through the whole job, still high in the IDLE cycle after done.
        clear_stats();
        start_job(30, 2, 3, 8'hB0, 8'hC0, 1'b1);
        feed(1'b0, 2, 8'hB0, '1);
        feed(1'b1, 3, 8'hC0, '1);
        wait_done();
        clear_stats();
        push_expect(30, 2, 3, 8'hB0, 8'hC0);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check("restart_from_idle", bus.busy, 1);
        feed(1'b0, 2, 8'hB0, '1);
        feed(1'b1, 3, 8'hC0, '1);
        wait_done();

        repeat (4) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/pe_sequencer.md
Name: pe_sequencer

Overview:
- Drives a single PE's load/compute control port, on the opposite side from the PE controller.
- Takes filter and ifmap words from global-buffer valid/ready streams and writes them into the PE scratchpads through the load_filter/load_ifmap interface.
- Then issues the 1-D convolution address sequence (filter addr, ifmap addr, psum addr) with en asserted, drains the PE pipeline, and reports done.

Parameters:
- DW, 8, data word width.
- FILT_AW, 6, filter scratchpad address width.
- IFMAP_AW, 4, ifmap scratchpad address width.
- PSUM_AW, 4, psum scratchpad address width.
- PE_LAT, 3, PE pipeline depth in cycles (address register + multiply + add) waited in DRAIN.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-low.
- start  in  1  one-cycle request to run a job; sampled only in IDLE.
- cfg_filt_base  in  FILT_AW  first filter scratchpad address.
- cfg_filt_len  in  5  filter taps S; legal range 1..16.
- cfg_ifmap_len  in  5  ifmap words W; legal range S..16.
- gb_filt_data  in  DW  filter word from global buffer.
- gb_filt_valid  in  1  filter word valid.
- gb_filt_ready  out  1  sequencer accepts filter word.
- gb_ifmap_data  in  DW  ifmap word from global buffer.
- gb_ifmap_valid  in  1  ifmap word valid.
- gb_ifmap_ready  out  1  sequencer accepts ifmap word.
- load_filter  out  1  filter scratchpad write strobe to PE.
- ld_addr_filter  out  FILT_AW  filter write address.
- filter  out  DW  filter write data.
- load_ifmap  out  1  ifmap scratchpad write strobe to PE.
- ld_addr_ifmap  out  IFMAP_AW  ifmap write address.
- ifmap  out  DW  ifmap write data.
- en  out  1  PE compute enable.
- sel_filter_addr  out  FILT_AW  filter read address for the current MAC.
- sel_ifmap_addr  out  IFMAP_AW  ifmap read address for the current MAC.
- psum_sel  out  PSUM_AW  psum address for the current MAC.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at job completion.
- err  out  1  one-cycle pulse on a rejected configuration.

Behaviour:
- Reset (rst=0, asynchronous): FSM goes to IDLE and all counters clear. Every output is 0.
  - This applies mid-job: no further load or en pulses are issued.
  - After release, a new start is required.
- All PE-side outputs and done/err are registered. Both ready outputs are combinational decodes of the state and counters.
- States: IDLE, LOAD_FILT, LOAD_IFMAP, COMPUTE, DRAIN, DONE.
- IDLE:
  - On start, latch cfg_* into job registers.
  - If S==0 or S>W or W>16: pulse err next cycle and stay in IDLE.
  - Otherwise go to LOAD_FILT.
  - start is ignored in every other state.
- LOAD_FILT:
  - gb_filt_ready=1 while fewer than S words have been accepted.
  - A transfer occurs in any cycle where valid&&ready.
  - The cycle after transfer k (k=0..S-1): load_filter=1, ld_addr_filter=cfg_filt_base+k (mod 2^FILT_AW wrap), filter=data.
  - No transfer means load_filter=0 that cycle; the address and data outputs hold their last values.
  - After transfer S-1: move to LOAD_IFMAP and drop ready in the same cycle.
- LOAD_IFMAP: same rules on the ifmap stream; ld_addr_ifmap=k for k=0..W-1; load_ifmap pulses per word. load_filter and load_ifmap are never high together.
- COMPUTE: entered the cycle after the last load_ifmap pulse.
  - E=W-S+1 outputs, S taps; s is the inner loop and e the outer.
  - Every cycle: en=1, sel_filter_addr=cfg_filt_base+s, sel_ifmap_addr=e+s, psum_sel=e.
  - Exactly E*S cycles with en=1, contiguous, with no bubbles.
  - After (e=E-1, s=S-1): go to DRAIN.
- DRAIN: en=0, sel_* hold their last values, wait PE_LAT cycles, then go to DONE.
- DONE: done=1 for one cycle, then IDLE. busy falls in the same cycle IDLE is entered.
- Stalls: valid low for any number of cycles stalls loading indefinitely with no timeout. Data presented while ready=0 is not consumed.

Test Plan:
- Basic run: base=10, S=3, W=5, both valid held high, filter data 1,2,3 and ifmap data 4..8.
  - Required: 3 load_filter pulses at addresses 10,11,12 with data 1,2,3.
  - Then 5 load_ifmap pulses at addresses 0..4.
  - Then 9 consecutive en cycles with (filt,ifmap,psum) = (10,0,0),(11,1,0),(12,2,0),(10,1,1)…(12,4,2).
  - Then 3 idle cycles and one done pulse; busy is high from the cycle after start through the done cycle.
- Stall: toggle gb_filt_valid 1,0,0,1,1 over S=3 → load_filter pulses only after accepted cycles; addresses contiguous; no duplicate writes.
- Bad configuration: S=6, W=4 → single err pulse, busy stays 0, no load or en activity; a following legal start runs normally.
- Edge configuration: S=1, W=16, base=63 → ld_addr_filter=63, ld_addr_ifmap 0..15, 16 en cycles with sel_filter_addr=63 and psum_sel=ifmap addr=0..15; also S=W=16 gives exactly 16 en cycles with psum_sel=0.
- Reset mid-COMPUTE: assert rst after 4 en cycles → all outputs 0 immediately (asynchronous); after release nothing happens until the next start.
- start held high during busy and at done → no restart until IDLE; a start asserted in the IDLE cycle after done begins a new job.
